// File: rtl/rvvi_csr_serializer.sv
// Serialises one retired instruction's multi-hot CSR write vector into
// (address, value) beats, lowest index first. Optional macro: RVVI_CSR_FILTER_EN.
module rvvi_csr_serializer #(
  parameter  int XLEN        = 64,
  parameter  int PMP_ENTRIES = 16,
  localparam int TOTAL_CSRS  = 36 + PMP_ENTRIES + PMP_ENTRIES / (XLEN == 64 ? 8 : 4),
  localparam int CNTW        = $clog2(TOTAL_CSRS + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [TOTAL_CSRS-1:0]        CSRWen,
  input  logic [TOTAL_CSRS*XLEN-1:0]   CSRValues,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [11:0]                  CSRAddr,
  output logic [XLEN-1:0]              CSRValue,
  output logic                         OutLast,
  output logic [CNTW-1:0]              OutCount
);

  localparam int IDXW         = $clog2(TOTAL_CSRS);
  localparam int PMPADDR_BASE = 'h3B0;
  localparam int PMPCFG_BASE  = 'h3A0;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                       state_q, state_d;
  logic [TOTAL_CSRS-1:0]        pending_q, pending_d;
  logic [TOTAL_CSRS*XLEN-1:0]   hold_q, hold_d;
  logic [TOTAL_CSRS-1:0]        captureMask;
  logic [IDXW-1:0]              sel;
  logic                         found;
  logic [CNTW-1:0]              count;
  logic                         capture;

  function automatic logic [11:0] addrOf(input logic [IDXW-1:0] idx);
    int i;
    i = int'(idx);
    addrOf = 12'h000;
    if (i < 36) begin
      case (i)
        0:  addrOf = 12'h300;  1:  addrOf = 12'h310;  2:  addrOf = 12'h305;
        3:  addrOf = 12'h341;  4:  addrOf = 12'h306;  5:  addrOf = 12'h320;
        6:  addrOf = 12'h302;  7:  addrOf = 12'h303;  8:  addrOf = 12'h344;
        9:  addrOf = 12'h304;  10: addrOf = 12'h301;  11: addrOf = 12'h30A;
        12: addrOf = 12'hF14;  13: addrOf = 12'h340;  14: addrOf = 12'h342;
        15: addrOf = 12'h343;  16: addrOf = 12'hF11;  17: addrOf = 12'hF12;
        18: addrOf = 12'hF13;  19: addrOf = 12'hF15;  20: addrOf = 12'h34A;
        21: addrOf = 12'h100;  22: addrOf = 12'h104;  23: addrOf = 12'h105;
        24: addrOf = 12'h141;  25: addrOf = 12'h106;  26: addrOf = 12'h10A;
        27: addrOf = 12'h180;  28: addrOf = 12'h140;  29: addrOf = 12'h143;
        30: addrOf = 12'h142;  31: addrOf = 12'h144;  32: addrOf = 12'h14D;
        33: addrOf = 12'h001;  34: addrOf = 12'h002;  35: addrOf = 12'h003;
        default: addrOf = 12'h000;
      endcase
    end else if (i < 36 + PMP_ENTRIES) begin
      addrOf = 12'(PMPADDR_BASE + i - 36);
    end else if (XLEN == 64) begin
      // RV64 only has even-numbered pmpcfg registers.
      addrOf = 12'(PMPCFG_BASE + 2 * (i - 36 - PMP_ENTRIES));
    end else begin
      addrOf = 12'(PMPCFG_BASE + (i - 36 - PMP_ENTRIES));
    end
  endfunction

  assign capture = (state_q == IDLE) && InValid;

`ifdef RVVI_CSR_FILTER_EN
  logic [XLEN-1:0] shadow_q [TOTAL_CSRS];

  always_comb begin
    captureMask = '0;
    for (int i = 0; i < TOTAL_CSRS; i++) begin
      captureMask[i] = CSRWen[i] && (CSRValues[i*XLEN +: XLEN] != shadow_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TOTAL_CSRS; i++) shadow_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < TOTAL_CSRS; i++) begin
        if (CSRWen[i]) shadow_q[i] <= CSRValues[i*XLEN +: XLEN];
      end
    end
  end
`else
  assign captureMask = CSRWen;
`endif

  // Priority pick of the lowest pending index plus the remaining-beat count.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    count = '0;
    for (int i = 0; i < TOTAL_CSRS; i++) begin
      if (pending_q[i] && !found) begin
        sel   = IDXW'(i);
        found = 1'b1;
      end
      count = count + CNTW'(pending_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          pending_d = captureMask;
          hold_d    = CSRValues;
          if (|captureMask) state_d = EMIT;
        end
      end
      EMIT: begin
        if (OutReady) begin
          pending_d[sel] = 1'b0;
          if (count == CNTW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  // Beat fields depend only on registered state, so they hold under backpressure.
  always_comb begin
    InReady  = (state_q == IDLE);
    OutValid = (state_q == EMIT);
    CSRAddr  = '0;
    CSRValue = '0;
    OutLast  = 1'b0;
    OutCount = '0;
    if (state_q == EMIT) begin
      CSRAddr  = addrOf(sel);
      CSRValue = hold_q[int'(sel)*XLEN +: XLEN];
      OutLast  = (count == CNTW'(1));
      OutCount = count;
    end
  end

  inValidWhileBusy: assert property (@(posedge clk) disable iff (!resetn) !(InValid && !InReady))
    else $error("InValid asserted while InReady is low");

endmodule

// File: tb/tb_rvvi_csr_serializer.sv
// Directed self-checking bench for rvvi_csr_serializer (XLEN=64, PMP_ENTRIES=16).
// Filter scenario is compiled in only when RVVI_CSR_FILTER_EN is defined.
module tb_rvvi_csr_serializer;

  localparam int XLEN = 64;
  localparam int NCSR = 54;
  localparam int CNTW = 6;

  logic                   clk;
  logic                   resetn;
  logic                   InValid;
  logic                   InReady;
  logic [NCSR-1:0]        CSRWen;
  logic [NCSR*XLEN-1:0]   CSRValues;
  logic                   OutValid;
  logic                   OutReady;
  logic [11:0]            CSRAddr;
  logic [XLEN-1:0]        CSRValue;
  logic                   OutLast;
  logic [CNTW-1:0]        OutCount;

  int checks;
  int errors;

  rvvi_csr_serializer #(.XLEN(XLEN), .PMP_ENTRIES(16)) dut (
    .clk(clk), .resetn(resetn), .InValid(InValid), .InReady(InReady),
    .CSRWen(CSRWen), .CSRValues(CSRValues), .OutValid(OutValid), .OutReady(OutReady),
    .CSRAddr(CSRAddr), .CSRValue(CSRValue), .OutLast(OutLast), .OutCount(OutCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic sendVector(input logic [NCSR-1:0] wen, input logic [NCSR*XLEN-1:0] vals);
    InValid   = 1'b1;
    CSRWen    = wen;
    CSRValues = vals;
    @(posedge clk);
    @(negedge clk);
    InValid   = 1'b0;
    CSRWen    = '0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0 || OutCount !== 6'd0 ||
        CSRAddr !== 12'h000 || CSRValue !== 64'd0 || OutLast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: InReady=%b OutValid=%b OutCount=%0d CSRAddr=%h CSRValue=%h OutLast=%b, want 1 0 0 000 0 0",
               InReady, OutValid, OutCount, CSRAddr, CSRValue, OutLast);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_bit;
    logic [NCSR*XLEN-1:0] v;
    v = '0;
    v[2*XLEN +: XLEN] = 64'h8000_0000_0000_1000;
    OutReady = 1'b1;
    sendVector(54'd1 << 2, v);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'h305 || CSRValue !== 64'h8000_0000_0000_1000 ||
        OutLast !== 1'b1 || OutCount !== 6'd1 || InReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_beat: valid=%b addr=%h value=%h last=%b count=%0d inready=%b, want 1 305 8000000000001000 1 1 0",
               OutValid, CSRAddr, CSRValue, OutLast, OutCount, InReady);
    end
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_idle: valid=%b inready=%b, want 0 1", OutValid, InReady);
    end
  endtask

  task automatic test_multi_hot;
    logic [NCSR*XLEN-1:0] v;
    logic [11:0] expAddr [3];
    logic [XLEN-1:0] expVal [3];
    expAddr = '{12'h300, 12'h340, 12'h003};
    expVal  = '{64'h11, 64'h2222, 64'h3333_0000};
    v = '0;
    v[0*XLEN  +: XLEN] = 64'h11;
    v[13*XLEN +: XLEN] = 64'h2222;
    v[35*XLEN +: XLEN] = 64'h3333_0000;
    OutReady = 1'b1;
    sendVector((54'd1 << 0) | (54'd1 << 13) | (54'd1 << 35), v);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (OutValid !== 1'b1 || CSRAddr !== expAddr[k] || CSRValue !== expVal[k] ||
          OutCount !== CNTW'(3 - k) || OutLast !== (k == 2)) begin
        errors++;
        $display("[TB] FAIL multi_beat%0d: valid=%b addr=%h value=%h count=%0d last=%b, want 1 %h %h %0d %b",
                 k, OutValid, CSRAddr, CSRValue, OutCount, OutLast, expAddr[k], expVal[k], 3 - k, k == 2);
      end
      @(negedge clk);
    end
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_idle: valid=%b inready=%b, want 0 1", OutValid, InReady);
    end
  endtask

  task automatic test_backpressure;
    logic [NCSR*XLEN-1:0] v;
    v = '0;
    v[1*XLEN +: XLEN] = 64'hAAAA;
    v[3*XLEN +: XLEN] = 64'hBBBB;
    OutReady = 1'b0;
    sendVector((54'd1 << 1) | (54'd1 << 3), v);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (OutValid !== 1'b1 || CSRAddr !== 12'h310 || CSRValue !== 64'hAAAA ||
          OutCount !== 6'd2 || OutLast !== 1'b0 || InReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall%0d: valid=%b addr=%h value=%h count=%0d last=%b inready=%b, want 1 310 aaaa 2 0 0",
                 k, OutValid, CSRAddr, CSRValue, OutCount, OutLast, InReady);
      end
      if (k < 2) @(negedge clk);
    end
    OutReady = 1'b1;
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'h341 || CSRValue !== 64'hBBBB ||
        OutCount !== 6'd1 || OutLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_second: valid=%b addr=%h value=%h count=%0d last=%b, want 1 341 bbbb 1 1",
               OutValid, CSRAddr, CSRValue, OutCount, OutLast);
    end
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_idle: valid=%b inready=%b, want 0 1", OutValid, InReady);
    end
  endtask

  task automatic test_pmp;
    logic [NCSR*XLEN-1:0] v;
    logic [11:0] expAddr [3];
    logic [XLEN-1:0] expVal [3];
    expAddr = '{12'h3B0, 12'h3BF, 12'h3A2};
    expVal  = '{64'h36, 64'h51, 64'h53};
    v = '0;
    v[36*XLEN +: XLEN] = 64'h36;
    v[51*XLEN +: XLEN] = 64'h51;
    v[53*XLEN +: XLEN] = 64'h53;
    OutReady = 1'b1;
    sendVector((54'd1 << 36) | (54'd1 << 51) | (54'd1 << 53), v);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (OutValid !== 1'b1 || CSRAddr !== expAddr[k] || CSRValue !== expVal[k]) begin
        errors++;
        $display("[TB] FAIL pmp_beat%0d: valid=%b addr=%h value=%h, want 1 %h %h",
                 k, OutValid, CSRAddr, CSRValue, expAddr[k], expVal[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_mask;
    OutReady = 1'b1;
    sendVector('0, '0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL zero_mask%0d: valid=%b inready=%b, want 0 1", k, OutValid, InReady);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [NCSR*XLEN-1:0] v;
    v = '0;
    v[8*XLEN  +: XLEN] = 64'h0808;
    v[12*XLEN +: XLEN] = 64'h1212;
    OutReady = 1'b1;
    sendVector(54'd1 << 8, v);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'h344 || OutLast !== 1'b1 || InReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%b addr=%h last=%b inready=%b, want 1 344 1 0",
               OutValid, CSRAddr, OutLast, InReady);
    end
    @(negedge clk);
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready: inready=%b, want 1", InReady);
    end
    sendVector(54'd1 << 12, v);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'hF14 || CSRValue !== 64'h1212) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%b addr=%h value=%h, want 1 f14 1212",
               OutValid, CSRAddr, CSRValue);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_emit;
    logic [NCSR*XLEN-1:0] v;
    v = '0;
    v[4*XLEN +: XLEN] = 64'h44;
    v[5*XLEN +: XLEN] = 64'h55;
    OutReady = 1'b0;
    sendVector((54'd1 << 4) | (54'd1 << 5), v);
    checks++;
    if (OutValid !== 1'b1 || OutCount !== 6'd2 || CSRAddr !== 12'h306) begin
      errors++;
      $display("[TB] FAIL mid_emit_pre: valid=%b count=%0d addr=%h, want 1 2 306",
               OutValid, OutCount, CSRAddr);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutCount !== 6'd0) begin
      errors++;
      $display("[TB] FAIL mid_emit_reset: valid=%b inready=%b count=%0d, want 0 1 0",
               OutValid, InReady, OutCount);
    end
    resetn   = 1'b1;
    OutReady = 1'b1;
    @(negedge clk);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_emit_discard: valid=%b, want 0", OutValid);
    end
  endtask

`ifdef RVVI_CSR_FILTER_EN
  task automatic test_filter;
    logic [NCSR*XLEN-1:0] v;
    v = '0;
    v[0 +: XLEN] = 64'd5;
    OutReady = 1'b1;
    sendVector(54'd1, v);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'h300 || CSRValue !== 64'd5) begin
      errors++;
      $display("[TB] FAIL filter_first: valid=%b addr=%h value=%h, want 1 300 5", OutValid, CSRAddr, CSRValue);
    end
    @(negedge clk);
    sendVector(54'd1, v);
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL filter_repeat: valid=%b inready=%b, want 0 1", OutValid, InReady);
    end
    v[0 +: XLEN] = 64'd6;
    sendVector(54'd1, v);
    checks++;
    if (OutValid !== 1'b1 || CSRAddr !== 12'h300 || CSRValue !== 64'd6) begin
      errors++;
      $display("[TB] FAIL filter_change: valid=%b addr=%h value=%h, want 1 300 6", OutValid, CSRAddr, CSRValue);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    InValid   = 1'b0;
    CSRWen    = '0;
    CSRValues = '0;
    OutReady  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_multi_hot();
    test_backpressure();
    test_pmp();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid_emit();
`ifdef RVVI_CSR_FILTER_EN
    test_filter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
